// File: rtl/i2c_uart_tx_core.sv
// UART transmitter for the PC-bound link: start bit, DBIT data bits LSB first, STOP_BITS stop bits.
// A new request may be taken on the done-tick cycle so frames can follow each other with no idle gap.
module i2c_uart_tx_core #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DBIT         = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] data_byte,
    output logic       tx,
    output logic       tx_done_tick,
    output logic       tx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic            stop_cnt_q, stop_cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            tx_q, tx_d;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        shreg_d      = shreg_q;
        tx_done_tick = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!tx_start) begin
                    shreg_d   = data_byte;
                    clk_cnt_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = '0;
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        stop_cnt_d = 1'b0;
                        state_d    = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = '0;
                    if (stop_cnt_q == STOP_LAST) begin
                        tx_done_tick = 1'b1;
                        // The packet stage requests the next byte in this same cycle.
                        if (!tx_start) begin
                            shreg_d = data_byte;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // tx is registered from the next state so it never depends combinationally on inputs.
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_uart_tx_core.sv
// Bench for i2c_uart_tx_core: two instances (1 and 2 stop bits), each compared cycle by cycle
// against a waveform expanded from the frame format whenever a request is accepted.
`timescale 1ns/1ps
module tb_i2c_uart_tx_core;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] tx_start;
    logic [7:0] data_byte [2];
    logic [1:0] tx_w, done_w, busy_w;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef logic [2:0] ent_q_t [$];
    ent_q_t exp_q [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    i2c_uart_tx_core #(.CLKS_PER_BIT(C), .DBIT(8), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .tx_start(tx_start[0]), .data_byte(data_byte[0]),
        .tx(tx_w[0]), .tx_done_tick(done_w[0]), .tx_busy(busy_w[0])
    );

    i2c_uart_tx_core #(.CLKS_PER_BIT(C), .DBIT(8), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .tx_start(tx_start[1]), .data_byte(data_byte[1]),
        .tx(tx_w[1]), .tx_done_tick(done_w[1]), .tx_busy(busy_w[1])
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected {tx, done, busy} for every cycle of one frame.
    task automatic push_frame(input int d, input logic [7:0] b);
        int stops;
        stops = (d == 0) ? 1 : 2;
        for (int i = 0; i < C; i++) exp_q[d].push_back(3'b001);
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < C; i++) exp_q[d].push_back({b[k], 2'b01});
        for (int i = 0; i < stops * C; i++)
            exp_q[d].push_back({1'b1, (i == stops * C - 1), 1'b1});
    endtask

    // Reference model: a request is taken when no frame is pending or on the final frame cycle.
    always @(posedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++)
                if (!tx_start[d] && exp_q[d].size() == 0) push_frame(d, data_byte[d]);
        end
    end

    always @(posedge reset) begin
        for (int d = 0; d < 2; d++) exp_q[d].delete();
    end

    // Monitor: one comparison per DUT per cycle, idle expected when nothing is queued.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [2:0] e;
            e = (exp_q[d].size() > 0) ? exp_q[d].pop_front() : 3'b100;
            check($sformatf("line_dut%0d", d), int'({tx_w[d], done_w[d], busy_w[d]}), int'(e));
        end
    end

    task automatic send(input int d, input logic [7:0] b);
        @(negedge clk); #1;
        tx_start[d]  = 1'b0;
        data_byte[d] = b;
        @(negedge clk); #1;
        tx_start[d]  = 1'b1;
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!done_w[d] && n < 100);
        if (!done_w[d]) check("done_timeout", int'(done_w[d]), 1);
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while ((exp_q[d].size() != 0 || busy_w[d]) && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        if (busy_w[d]) check("idle_timeout", int'(busy_w[d]), 0);
    endtask

    initial begin
        logic [7:0] pkt [5];
        int         t_done [5];
        pkt = '{8'hFF, 8'h48, 8'h01, 8'h34, 8'hFF};

        reset        = 1'b1;
        tx_start     = 2'b11;
        data_byte[0] = 8'h00;
        data_byte[1] = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            check($sformatf("reset_state%0d", d), int'({tx_w[d], done_w[d], busy_w[d]}), 3'b100);
        reset = 1'b0;

        // Single 0xA5 frame.
        send(0, 8'hA5);
        wait_idle(0);

        // Five-byte packet chained on done ticks.
        @(negedge clk); #1;
        tx_start[0]  = 1'b0;
        data_byte[0] = pkt[0];
        @(negedge clk); #1;
        tx_start[0]  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_done(0);
            t_done[i] = cyc;
            if (i > 0) check("pkt_tick_spacing", t_done[i] - t_done[i-1], 40);
            if (i < 4) begin
                tx_start[0]  = 1'b0;
                data_byte[0] = pkt[i+1];
                @(negedge clk); #1;
                tx_start[0]  = 1'b1;
            end
        end
        wait_idle(0);

        // Mid-frame request during data bit 3 is ignored.
        send(0, 8'hC3);
        repeat (17) @(negedge clk);
        #1;
        tx_start[0]  = 1'b0;
        data_byte[0] = 8'h00;
        @(negedge clk); #1;
        tx_start[0]  = 1'b1;
        wait_idle(0);

        // Reset during data bit 5, with a request pending that must be dropped.
        send(0, 8'h5A);
        repeat (25) @(negedge clk);
        #2;
        reset        = 1'b1;
        tx_start[0]  = 1'b0;
        data_byte[0] = 8'hFF;
        #1;
        check("reset_async", int'({tx_w[0], done_w[0], busy_w[0]}), 3'b100);
        @(negedge clk); #1;
        tx_start[0] = 1'b1;
        reset       = 1'b0;
        send(0, 8'h81);
        wait_idle(0);

        // Two stop bits.
        send(1, 8'h0F);
        wait_idle(1);

        // tx_start held low: back-to-back 0x55 frames, then release.
        @(negedge clk); #1;
        tx_start[0]  = 1'b0;
        data_byte[0] = 8'h55;
        repeat (100) @(negedge clk);
        #1;
        tx_start[0] = 1'b1;
        wait_idle(0);

        // Randomised requests and data changes on both instances.
        repeat (3000) begin
            @(negedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                tx_start[d]  = ($urandom_range(0, 15) != 0);
                data_byte[d] = 8'($urandom);
            end
        end
        tx_start = 2'b11;
        wait_idle(0);
        wait_idle(1);
        @(negedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
